// File: rtl/imem_boot_fetch_ctrl.sv
// rtl/imem_boot_fetch_ctrl.sv - boot loader sequencer and one-entry fetch stage for the instruction memory
module imem_boot_fetch_ctrl #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              booting,
    output logic              boot_overflow,
    output logic              misalign
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] pc;
    logic              in_boot;
    logic              load;

    assign in_boot = (state == ST_BOOT);

    // Gating with reset drops an in-flight loader byte the moment reset rises.
    assign ld_ready  = in_boot && !reset;
    assign mem_we    = ld_ready && ld_valid;
    assign mem_waddr = wptr;
    assign mem_wdata = ld_byte;
    assign mem_raddr = pc;
    assign booting   = in_boot;
    assign load      = !if_valid || if_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_BOOT;
            wptr          <= '0;
            pc            <= RESET_PC;
            if_valid      <= 1'b0;
            if_instr      <= '0;
            if_pc         <= '0;
            boot_overflow <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    if (ld_valid) begin
                        wptr <= wptr + ADDR_W'(1);
                        if (&wptr) begin
                            boot_overflow <= 1'b1;
                        end
                        if (ld_last) begin
                            state <= ST_RUN;
                            pc    <= RESET_PC;
                        end
                    end
                end
                ST_RUN: begin
                    // A redirect discards the held instruction even if decode is taking it.
                    if (redirect_valid) begin
                        if_valid <= 1'b0;
                        pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
                        if (redirect_pc[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                        end
                    end else if (load) begin
                        if_instr <= mem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + ADDR_W'(4);
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_fetch_ctrl.sv
// tb/tb_imem_boot_fetch_ctrl.sv - vector table plus fetch scoreboard bench for imem_boot_fetch_ctrl
module tb_imem_boot_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready, ld_last;
    logic [7:0]  ld_byte;
    logic        mem_we;
    logic [9:0]  mem_waddr, mem_raddr;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_instr;
    logic [9:0]  if_pc;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        booting, boot_overflow, misalign;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_boot_fetch_ctrl #(.ADDR_W(10), .RESET_PC(10'd0)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte), .ld_last(ld_last),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .booting(booting), .boot_overflow(boot_overflow), .misalign(misalign)
    );

    // Instruction memory model written by the DUT, and the bench's own reference image.
    logic [7:0] mem  [1024];
    logic [7:0] refm [1024];
    logic [9:0] ra1, ra2, ra3;
    assign ra1 = mem_raddr + 10'd1;
    assign ra2 = mem_raddr + 10'd2;
    assign ra3 = mem_raddr + 10'd3;
    assign mem_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[mem_raddr]};

    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] = mem_wdata;
    end

    function automatic logic [31:0] ref_word(input logic [9:0] p);
        logic [9:0] a1, a2, a3;
        a1 = p + 10'd1;
        a2 = p + 10'd2;
        a3 = p + 10'd3;
        return {refm[a3], refm[a2], refm[a1], refm[p]};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic [9:0] exp_waddr;
    } vec_t;
    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_seq(input logic [9:0] start, input int n);
        logic [9:0] p;
        p = start;
        for (int k = 0; k < n; k++) begin
            q.push_back('{instr: ref_word(p), pc: p});
            p = p + 10'd4;
        end
    endtask

    task automatic cycle();
        exp_t e;
        #1;
        if (if_valid && if_ready && !redirect_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=%h expected=none", if_pc);
            end else begin
                e = q.pop_front();
                check("sb_instr", if_instr, e.instr);
                check("sb_pc", 32'(if_pc), 32'(e.pc));
            end
        end
        tick();
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check("sb_drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 8'(i) ^ 8'h5A;
            refm[i] = 8'(i) ^ 8'h5A;
        end
        vt[0] = '{8'h13, 1'b0, 10'd0};
        vt[1] = '{8'h01, 1'b0, 10'd1};
        vt[2] = '{8'h50, 1'b0, 10'd2};
        vt[3] = '{8'h00, 1'b0, 10'd3};
        vt[4] = '{8'h93, 1'b0, 10'd4};
        vt[5] = '{8'h01, 1'b0, 10'd5};
        vt[6] = '{8'h31, 1'b0, 10'd6};
        vt[7] = '{8'h00, 1'b1, 10'd7};

        reset = 1'b1;
        ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
        if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 10'h0;
        #1;
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc", 32'(if_pc), 32'd0);
        check("rst_overflow", 32'(boot_overflow), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_booting", 32'(booting), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Boot stream from the vector table.
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_byte = vt[i].b; ld_last = vt[i].last;
            refm[vt[i].exp_waddr] = vt[i].b;
            #1;
            check("boot_mem_we", 32'(mem_we), 32'd1);
            check("boot_waddr", 32'(mem_waddr), 32'(vt[i].exp_waddr));
            check("boot_wdata", 32'(mem_wdata), 32'(vt[i].b));
            check("boot_ld_ready", 32'(ld_ready), 32'd1);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("run_booting", 32'(booting), 32'd0);
        check("run_ld_ready", 32'(ld_ready), 32'd0);
        check("run_first_latency", 32'(if_valid), 32'd0);
        tick();
        check("first_valid", 32'(if_valid), 32'd1);
        check("first_instr", if_instr, 32'h00500113);
        check("first_pc", 32'(if_pc), 32'd0);

        // Stall: held instruction and pc must not move.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_instr", if_instr, 32'h00500113);
            check("stall_pc", 32'(if_pc), 32'd0);
            check("stall_raddr", 32'(mem_raddr), 32'd4);
        end
        push_seq(10'd0, 6);
        if_ready = 1'b1;
        run_until_empty(50);
        if_ready = 1'b0;

        // Redirect while stalled.
        check("pre_redir_valid", 32'(if_valid), 32'd1);
        check("pre_redir_misalign", 32'(misalign), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 10'h10;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", 32'(if_valid), 32'd0);
        check("redir_raddr", 32'(mem_raddr), 32'h10);
        tick();
        check("redir_valid", 32'(if_valid), 32'd1);
        check("redir_pc", 32'(if_pc), 32'h10);
        check("redir_instr", if_instr, ref_word(10'h10));
        redirect_valid = 1'b1; redirect_pc = 10'h13;
        tick();
        redirect_valid = 1'b0;
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_flush", 32'(if_valid), 32'd0);
        check("mis_raddr", 32'(mem_raddr), 32'h10);
        tick();
        check("mis_pc", 32'(if_pc), 32'h10);

        // Loader traffic during RUN is ignored while fetch streams on.
        q.delete();
        push_seq(10'h10, 5);
        ld_valid = 1'b1; ld_byte = 8'hFF;
        if_ready = 1'b1;
        #1;
        check("run_ld_mem_we", 32'(mem_we), 32'd0);
        check("run_ld_ready2", 32'(ld_ready), 32'd0);
        run_until_empty(50);
        ld_valid = 1'b0;
        check("run_no_write", {mem[11], mem[10], mem[9], mem[8]}, ref_word(10'd8));

        // Asynchronous reset in RUN with an instruction held.
        check("pre_rst_valid", 32'(if_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("rrst_if_valid", 32'(if_valid), 32'd0);
        check("rrst_if_instr", if_instr, 32'd0);
        check("rrst_if_pc", 32'(if_pc), 32'd0);
        check("rrst_misalign", 32'(misalign), 32'd0);
        check("rrst_booting", 32'(booting), 32'd1);
        check("rrst_raddr", 32'(mem_raddr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        if_ready = 1'b0;

        // Redirect in BOOT is ignored.
        redirect_valid = 1'b1; redirect_pc = 10'h41;
        tick();
        tick();
        check("boot_redir_raddr", 32'(mem_raddr), 32'd0);
        check("boot_redir_mis", 32'(misalign), 32'd0);
        check("boot_redir_booting", 32'(booting), 32'd1);
        check("boot_redir_we", 32'(mem_we), 32'd0);
        redirect_valid = 1'b0;

        // Reset mid-BOOT after three bytes drops the fourth and restarts wptr.
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_byte = 8'(8'h11 * (i + 1)); ld_last = 1'b0;
            refm[i] = 8'(8'h11 * (i + 1));
            tick();
        end
        ld_byte = 8'h44;
        #1;
        check("mid_waddr", 32'(mem_waddr), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_waddr", 32'(mem_waddr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ld_byte = 8'h55;
        refm[0] = 8'h55;
        #1;
        check("restart_waddr", 32'(mem_waddr), 32'd0);
        check("restart_we", 32'(mem_we), 32'd1);
        tick();
        ld_valid = 1'b0;
        check("dropped_byte", 32'(mem[3]), 32'(refm[3]));
        check("restart_written", 32'(mem[0]), 32'h55);

        // Full-memory load with overflow, then fetch wraps past the top.
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i <= 1024; i++) begin
            ld_valid = 1'b1; ld_byte = 8'(i * 7 + 3); ld_last = (i == 1024);
            refm[i % 1024] = 8'(i * 7 + 3);
            #1;
            if (i == 1023) check("ovf_before", 32'(boot_overflow), 32'd0);
            if (i == 1024) begin
                check("ovf_after", 32'(boot_overflow), 32'd1);
                check("ovf_wrap_waddr", 32'(mem_waddr), 32'd0);
            end
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        q.delete();
        push_seq(10'd0, 258);
        if_ready = 1'b1;
        run_until_empty(400);
        check("ovf_sticky", 32'(boot_overflow), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_fetch_ctrl.md
Name: imem_boot_fetch_ctrl

Overview:
- Sequencer in front of the byte-addressed instruction memory.
- After reset it runs a boot phase: it streams program bytes from a loader port into the memory, one byte per handshake.
- It then switches to run mode and drives the fetch PC, presenting {instr, pc} to decode through a one-entry registered stage with valid/ready handshake and branch/jump redirect flush.
- Sits between the instruction memory and the IF/ID boundary of the pipeline.

Parameters:
- ADDR_W, 10, byte-address width of instruction memory (1024 bytes).
- RESET_PC, 0, first fetch address after boot; must be 4-byte aligned.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- ld_valid  input  1  loader byte valid
- ld_ready  output  1  controller accepts loader byte
- ld_byte  input  8  program byte, written at the next sequential address
- ld_last  input  1  qualifies the final byte of the program
- mem_we  output  1  instruction memory byte write enable
- mem_waddr  output  ADDR_W  byte write address
- mem_wdata  output  8  byte write data
- mem_raddr  output  ADDR_W  fetch address (combinational read port, word = bytes raddr..raddr+3, little-endian)
- mem_rdata  input  32  combinational read data
- if_valid  output  1  fetched instruction valid to decode
- if_ready  input  1  decode accepts instruction
- if_instr  output  32  fetched instruction
- if_pc  output  ADDR_W  address of if_instr
- redirect_valid  input  1  branch/jump taken, flush and refetch
- redirect_pc  input  ADDR_W  redirect target
- booting  output  1  high while in BOOT
- boot_overflow  output  1  sticky: loader wrote past the top of memory
- misalign  output  1  sticky: redirect_pc[1:0] != 0

Behaviour:
- Reset (async): state=BOOT, wptr=0, pc=RESET_PC.
- Reset values: if_valid=0, if_instr=0, if_pc=0, boot_overflow=0, misalign=0, mem_we=0.
- Memory contents are not cleared by this block.
- States: BOOT, RUN. No other transitions; only reset returns to BOOT.

BOOT:
- ld_ready=1, booting=1, if_valid=0.
- Combinational write path: mem_we=ld_valid, mem_waddr=wptr, mem_wdata=ld_byte.
- On ld_valid&&ld_ready: wptr<=wptr+1, modulo 2^ADDR_W.
- If that byte was written at wptr=2^ADDR_W-1, set boot_overflow (sticky) and wrap wptr to 0. Loading continues and overwrites from 0.
- ld_last with handshake: the byte is written, state<=RUN next edge, pc<=RESET_PC.
- ld_last without ld_valid is ignored.
- redirect_valid is ignored in BOOT.

RUN:
- ld_ready=0, mem_we=0, booting=0. Loader bytes are ignored.
- mem_raddr=pc.
- Load condition: load = !if_valid || if_ready.
- Redirect has priority over load. When redirect_valid:
  - if_valid<=0 (flush the held instruction, whether or not decode is accepting it this cycle).
  - pc<={redirect_pc[ADDR_W-1:2],2'b00}.
  - misalign<=1 if redirect_pc[1:0]!=0.
  - Fetch of the target occurs the following cycle, so redirect-to-if_valid latency is 2 edges.
- Otherwise, on load: if_instr<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (modulo 2^ADDR_W).
  - pc at 2^ADDR_W-4 wraps to 0.
- Otherwise (if_valid&&!if_ready): hold if_instr, if_pc, pc.
- Throughput: one instruction per cycle while if_ready=1.
- First if_valid appears 1 edge after entering RUN (2 edges after the ld_last handshake).
- Reset mid-operation: everything returns to BOOT reset values immediately (async). An in-flight loader byte is dropped and the held instruction is discarded.

Test Plan:
1. Reset, stream 8 bytes 13 01 50 00 93 01 31 00 (last on 8th), if_ready=1 -> mem writes at 0..7, booting falls; if_valid=1 with (instr,pc) = (0x00500113,0) then (0x00310193,4), then pc 8, 12, ... each cycle.
2. Run with if_ready=0 for 3 cycles after first valid -> if_instr=0x00500113, if_pc=0 held stable; pc not advanced. Raise if_ready -> pc 4 presented next cycle.
3. Redirect_valid with redirect_pc=0x10 while if_valid=1, if_ready=0 -> next cycle if_valid=0; the cycle after, if_pc=0x10. Redirect_pc=0x13 -> fetch from 0x10 and misalign=1.
4. Load 1025 bytes (last on 1025th) -> boot_overflow=1 after byte 1024; byte 1025 written at address 0. Fetch reaching pc=1020 then wraps to pc=0.
5. Assert reset mid-BOOT after 3 bytes, and separately in RUN with if_valid=1 -> outputs immediately go to reset values, booting=1, wptr restarts at 0.
6. ld_valid=1 during RUN and redirect_valid=1 during BOOT -> no mem_we, no state/pc change.
